// File: rtl/arq_seqn_if.sv
// Header, payload and TX-decision signals between the link controller and
// the ARQ/SEQN engine. The master modport drives the engine's inputs; the
// slave modport is the engine itself.
interface arq_seqn_if;
    logic       pk_encode;
    logic [2:0] ms_lt_addr;
    logic       hec_endp;
    logic       dec_hecgood;
    logic       lt_addressed;
    logic       rx_arqn;
    logic       rx_flow;
    logic       rx_seqn;
    logic       pktype_data;
    logic       py_endp;
    logic       dec_crcgood;
    logic       tx_packet_st_p;
    logic       txpktype_data;
    logic       regi_txdatready;
    logic       regi_aclrxbufempty;
    logic       regi_flush_p;
    logic [2:0] regi_flush_lt;
    logic       txpk_seqn;
    logic       txpk_arqn;
    logic       txpk_flow;
    logic       sendnewpy;
    logic       newpy_int_p;
    logic [7:0] dec_arqn;
    logic [7:0] dec_flow;
    logic       rx_newpy_p;
    logic       rx_dup_p;
    logic [1:0] arq_state;

    modport master (
        output pk_encode, ms_lt_addr, hec_endp, dec_hecgood, lt_addressed,
               rx_arqn, rx_flow, rx_seqn, pktype_data, py_endp, dec_crcgood,
               tx_packet_st_p, txpktype_data, regi_txdatready,
               regi_aclrxbufempty, regi_flush_p, regi_flush_lt,
        input  txpk_seqn, txpk_arqn, txpk_flow, sendnewpy, newpy_int_p,
               dec_arqn, dec_flow, rx_newpy_p, rx_dup_p, arq_state
    );

    modport slave (
        input  pk_encode, ms_lt_addr, hec_endp, dec_hecgood, lt_addressed,
               rx_arqn, rx_flow, rx_seqn, pktype_data, py_endp, dec_crcgood,
               tx_packet_st_p, txpktype_data, regi_txdatready,
               regi_aclrxbufempty, regi_flush_p, regi_flush_lt,
        output txpk_seqn, txpk_arqn, txpk_flow, sendnewpy, newpy_int_p,
               dec_arqn, dec_flow, rx_newpy_p, rx_dup_p, arq_state
    );
endinterface

// File: rtl/arq_seqn_ctrl.sv
// Per-LT_ADDR ARQ/SEQN engine for the ACL link. Tracks received ARQN/FLOW,
// judges received payloads (new / duplicate / CRC fail) to build the
// outgoing ARQN, and picks new-payload vs retransmit at each TX start.
module arq_seqn_ctrl #(
    parameter logic SEQN_INIT   = 1'b1,
    parameter logic RX_ARQN_RST = 1'b0
) (
    input  logic         clk_6M,
    input  logic         rstz,
    arq_seqn_if.slave    bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_PY = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    // Per-LT state
    logic [7:0] seqn_tx_q,  seqn_tx_d;
    logic [7:0] seqn_old_q, seqn_old_d;
    logic [7:0] txarqn_q,   txarqn_d;
    logic [7:0] fresh_q,    fresh_d;
    logic [7:0] dec_arqn_q, dec_arqn_d;
    logic [7:0] dec_flow_q, dec_flow_d;

    // RX FSM and values latched from the header for the payload check
    logic [1:0] state_q,    state_d;
    logic       lat_seqn_q, lat_seqn_d;
    logic [2:0] lat_lt_q,   lat_lt_d;

    // Registered outputs
    logic txpk_seqn_q,   txpk_seqn_d;
    logic txpk_arqn_q,   txpk_arqn_d;
    logic txpk_flow_q,   txpk_flow_d;
    logic sendnewpy_q,   sendnewpy_d;
    logic newpy_int_q,   newpy_int_d;
    logic rx_newpy_q,    rx_newpy_d;
    logic rx_dup_q,      rx_dup_d;

    logic       tx_go_s;
    logic [2:0] lt_s;

    assign tx_go_s = bus.tx_packet_st_p & bus.pk_encode;
    assign lt_s    = bus.ms_lt_addr;

    // Next-state logic: TX decision first, then RX updates (RX wins over the
    // TX clear of dec_arqn), then flush last so its set-to-1 wins.
    always_comb begin
        seqn_tx_d   = seqn_tx_q;
        seqn_old_d  = seqn_old_q;
        txarqn_d    = txarqn_q;
        fresh_d     = fresh_q;
        dec_arqn_d  = dec_arqn_q;
        dec_flow_d  = dec_flow_q;
        state_d     = state_q;
        lat_seqn_d  = lat_seqn_q;
        lat_lt_d    = lat_lt_q;
        txpk_seqn_d = txpk_seqn_q;
        txpk_arqn_d = txpk_arqn_q;
        txpk_flow_d = txpk_flow_q;
        sendnewpy_d = sendnewpy_q;
        newpy_int_d = 1'b0;
        rx_newpy_d  = 1'b0;
        rx_dup_d    = 1'b0;

        // TX decision uses the registered (pre-flush) per-LT values
        if (tx_go_s) begin
            txpk_arqn_d    = txarqn_q[lt_s];
            txarqn_d[lt_s] = 1'b0;
            txpk_flow_d    = bus.regi_aclrxbufempty;
            if (!bus.txpktype_data) begin
                txpk_seqn_d = seqn_tx_q[lt_s];
                sendnewpy_d = 1'b0;
            end else if (lt_s == 3'd0) begin
                if (bus.regi_txdatready) begin
                    seqn_tx_d[0] = ~seqn_tx_q[0];
                    txpk_seqn_d  = ~seqn_tx_q[0];
                    sendnewpy_d  = 1'b1;
                    newpy_int_d  = 1'b1;
                end else begin
                    txpk_seqn_d = seqn_tx_q[0];
                    sendnewpy_d = 1'b0;
                end
            end else if (fresh_q[lt_s] && bus.regi_txdatready) begin
                txpk_seqn_d   = seqn_tx_q[lt_s];
                sendnewpy_d   = 1'b1;
                fresh_d[lt_s] = 1'b0;
                newpy_int_d   = 1'b1;
            end else if (dec_arqn_q[lt_s] && dec_flow_q[lt_s] && bus.regi_txdatready) begin
                seqn_tx_d[lt_s]  = ~seqn_tx_q[lt_s];
                txpk_seqn_d      = ~seqn_tx_q[lt_s];
                sendnewpy_d      = 1'b1;
                dec_arqn_d[lt_s] = 1'b0;
                newpy_int_d      = 1'b1;
            end else begin
                txpk_seqn_d = seqn_tx_q[lt_s];
                sendnewpy_d = 1'b0;
            end
        end else begin
            txpk_seqn_d = txpk_seqn_q;
        end

        // RX FSM
        case (state_q)
            ST_IDLE: begin
                if (!bus.pk_encode && bus.hec_endp) begin
                    if (bus.dec_hecgood) begin
                        if (bus.lt_addressed) begin
                            dec_arqn_d[lt_s] = bus.rx_arqn;
                            dec_flow_d[lt_s] = bus.rx_flow;
                            if (bus.pktype_data) begin
                                lat_seqn_d = bus.rx_seqn;
                                lat_lt_d   = lt_s;
                                state_d    = ST_WAIT_PY;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // failed header is treated as a NAK
                        dec_arqn_d[lt_s] = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_PY: begin
                if (!bus.pk_encode && bus.py_endp) begin
                    state_d = ST_IDLE;
                    if (lat_seqn_q == seqn_old_q[lat_lt_q]) begin
                        txarqn_d[lat_lt_q] = 1'b1;
                        rx_dup_d           = 1'b1;
                    end else if (bus.dec_crcgood) begin
                        txarqn_d[lat_lt_q]   = 1'b1;
                        seqn_old_d[lat_lt_q] = lat_seqn_q;
                        rx_newpy_d           = 1'b1;
                    end else begin
                        txarqn_d[lat_lt_q] = 1'b0;
                    end
                end else if (bus.tx_packet_st_p) begin
                    // our slot turned to TX before the payload ended
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_WAIT_PY;
                end
            end
            ST_ABORT: begin
                txarqn_d[lat_lt_q] = 1'b0;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush forces an ACK so the next TX moves on to a new payload
        if (bus.regi_flush_p) begin
            dec_arqn_d[bus.regi_flush_lt] = 1'b1;
            dec_flow_d[bus.regi_flush_lt] = 1'b1;
        end else begin
            dec_flow_d = dec_flow_d;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            seqn_tx_q   <= {8{SEQN_INIT}};
            seqn_old_q  <= {8{~SEQN_INIT}};
            txarqn_q    <= 8'h00;
            fresh_q     <= 8'hFF;
            dec_arqn_q  <= {8{RX_ARQN_RST}};
            dec_flow_q  <= 8'hFF;
            state_q     <= ST_IDLE;
            lat_seqn_q  <= 1'b0;
            lat_lt_q    <= 3'd0;
            txpk_seqn_q <= SEQN_INIT;
            txpk_arqn_q <= 1'b0;
            txpk_flow_q <= 1'b1;
            sendnewpy_q <= 1'b0;
            newpy_int_q <= 1'b0;
            rx_newpy_q  <= 1'b0;
            rx_dup_q    <= 1'b0;
        end else begin
            seqn_tx_q   <= seqn_tx_d;
            seqn_old_q  <= seqn_old_d;
            txarqn_q    <= txarqn_d;
            fresh_q     <= fresh_d;
            dec_arqn_q  <= dec_arqn_d;
            dec_flow_q  <= dec_flow_d;
            state_q     <= state_d;
            lat_seqn_q  <= lat_seqn_d;
            lat_lt_q    <= lat_lt_d;
            txpk_seqn_q <= txpk_seqn_d;
            txpk_arqn_q <= txpk_arqn_d;
            txpk_flow_q <= txpk_flow_d;
            sendnewpy_q <= sendnewpy_d;
            newpy_int_q <= newpy_int_d;
            rx_newpy_q  <= rx_newpy_d;
            rx_dup_q    <= rx_dup_d;
        end
    end

    assign bus.txpk_seqn   = txpk_seqn_q;
    assign bus.txpk_arqn   = txpk_arqn_q;
    assign bus.txpk_flow   = txpk_flow_q;
    assign bus.sendnewpy   = sendnewpy_q;
    assign bus.newpy_int_p = newpy_int_q;
    assign bus.dec_arqn    = dec_arqn_q;
    assign bus.dec_flow    = dec_flow_q;
    assign bus.rx_newpy_p  = rx_newpy_q;
    assign bus.rx_dup_p    = rx_dup_q;
    assign bus.arq_state   = state_q;

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Scenario bench for arq_seqn_ctrl. Expected TX header results
// {seqn,arqn,flow,sendnewpy,newpy_int_p} and RX pulses {newpy,dup} are
// queued when stimulus is driven and popped when the DUT responds.
module tb_arq_seqn_ctrl;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;

    always #83 clk_6M = ~clk_6M;

    arq_seqn_if bus ();

    arq_seqn_ctrl #(.SEQN_INIT(1'b1), .RX_ARQN_RST(1'b0)) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] tx_q [$];
    logic [1:0] rx_q [$];
    logic [4:0] exp5, obs5;
    logic [1:0] exp2, obs2;

    // TX pulse on one LT; returns at the negedge where the decision is visible
    task automatic tx_pulse(input logic [2:0] lt, input logic data, input logic rdy,
                            input logic bufe, input logic flush);
        @(negedge clk_6M);
        bus.pk_encode = 1'b1; bus.ms_lt_addr = lt; bus.tx_packet_st_p = 1'b1;
        bus.txpktype_data = data; bus.regi_txdatready = rdy;
        bus.regi_aclrxbufempty = bufe; bus.regi_flush_p = flush; bus.regi_flush_lt = lt;
        @(negedge clk_6M);
        bus.tx_packet_st_p = 1'b0; bus.regi_flush_p = 1'b0;
        bus.pk_encode = 1'b0; bus.regi_txdatready = 1'b0;
    endtask

    task automatic rx_hdr(input logic [2:0] lt, input logic good, input logic addr,
                          input logic arqn, input logic flow, input logic seqn, input logic data);
        @(negedge clk_6M);
        bus.pk_encode = 1'b0; bus.ms_lt_addr = lt; bus.hec_endp = 1'b1;
        bus.dec_hecgood = good; bus.lt_addressed = addr; bus.rx_arqn = arqn;
        bus.rx_flow = flow; bus.rx_seqn = seqn; bus.pktype_data = data;
        @(negedge clk_6M);
        bus.hec_endp = 1'b0;
    endtask

    task automatic rx_py(input logic crc);
        @(negedge clk_6M);
        bus.pk_encode = 1'b0; bus.py_endp = 1'b1; bus.dec_crcgood = crc;
        @(negedge clk_6M);
        bus.py_endp = 1'b0;
    endtask

    task automatic test_reset();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== 5'b10100) begin n_err++; $display("FAIL reset_tx got=%b exp=%b", obs5, 5'b10100); end
        n_vec++;
        if ({bus.arq_state, bus.rx_newpy_p, bus.rx_dup_p} !== 4'b0000) begin
            n_err++; $display("FAIL reset_state got=%b exp=0000", {bus.arq_state, bus.rx_newpy_p, bus.rx_dup_p});
        end
        n_vec++;
        if ({bus.dec_arqn, bus.dec_flow} !== 16'h00FF) begin
            n_err++; $display("FAIL reset_dec got=%h exp=00ff", {bus.dec_arqn, bus.dec_flow});
        end
    endtask

    task automatic test_first_tx();
        tx_q.push_back(5'b10111);
        tx_pulse(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL first_tx got=%b exp=%b", obs5, exp5); end
        @(negedge clk_6M);
        n_vec++;
        if (bus.newpy_int_p !== 1'b0) begin n_err++; $display("FAIL newpy_once got=%b exp=0", bus.newpy_int_p); end
    endtask

    task automatic test_ack_advance();
        rx_hdr(3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({bus.dec_arqn[3], bus.dec_flow[3]} !== 2'b11) begin
            n_err++; $display("FAIL ack_latch got=%b exp=11", {bus.dec_arqn[3], bus.dec_flow[3]});
        end
        tx_q.push_back(5'b00111);
        tx_pulse(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL ack_tx got=%b exp=%b", obs5, exp5); end
        n_vec++;
        if (bus.dec_arqn[3] !== 1'b0) begin n_err++; $display("FAIL ack_clear got=%b exp=0", bus.dec_arqn[3]); end
    endtask

    task automatic test_nak_retx();
        rx_hdr(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tx_q.push_back(5'b00000);
        tx_pulse(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL nak_retx got=%b exp=%b", obs5, exp5); end
    endtask

    task automatic test_rx_data();
        logic [1:0] rx_exp [2] = '{2'b10, 2'b01};
        logic       crc    [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            rx_hdr(3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            n_vec++;
            if (bus.arq_state !== 2'd1) begin n_err++; $display("FAIL rx_wait%0d got=%0d exp=1", i, bus.arq_state); end
            rx_q.push_back(rx_exp[i]);
            rx_py(crc[i]);
            exp2 = rx_q.pop_front();
            obs2 = {bus.rx_newpy_p, bus.rx_dup_p};
            n_vec++;
            if (obs2 !== exp2) begin n_err++; $display("FAIL rx_pulse%0d got=%b exp=%b", i, obs2, exp2); end
            tx_q.push_back(5'b11100);
            tx_pulse(3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
            exp5 = tx_q.pop_front();
            obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
            n_vec++;
            if (obs5 !== exp5) begin n_err++; $display("FAIL rx_ack_tx%0d got=%b exp=%b", i, obs5, exp5); end
        end
        tx_q.push_back(5'b10100);
        tx_pulse(3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL arqn_once got=%b exp=%b", obs5, exp5); end
    endtask

    task automatic test_hec_fail();
        rx_hdr(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.dec_arqn[4], bus.dec_flow[4]} !== 2'b10) begin
            n_err++; $display("FAIL hec_pre got=%b exp=10", {bus.dec_arqn[4], bus.dec_flow[4]});
        end
        rx_hdr(3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({bus.dec_arqn[4], bus.dec_flow[4]} !== 2'b00) begin
            n_err++; $display("FAIL hec_nak got=%b exp=00", {bus.dec_arqn[4], bus.dec_flow[4]});
        end
    endtask

    task automatic test_abort();
        rx_hdr(3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rx_q.push_back(2'b10);
        rx_py(1'b1);
        exp2 = rx_q.pop_front();
        obs2 = {bus.rx_newpy_p, bus.rx_dup_p};
        n_vec++;
        if (obs2 !== exp2) begin n_err++; $display("FAIL abort_setup got=%b exp=%b", obs2, exp2); end
        rx_hdr(3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tx_q.push_back(5'b10100);
        tx_pulse(3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL abort_tx got=%b exp=%b", obs5, exp5); end
        n_vec++;
        if (bus.arq_state !== 2'd2) begin n_err++; $display("FAIL abort_state got=%0d exp=2", bus.arq_state); end
        @(negedge clk_6M);
        n_vec++;
        if (bus.arq_state !== 2'd0) begin n_err++; $display("FAIL abort_idle got=%0d exp=0", bus.arq_state); end
        tx_q.push_back(5'b10100);
        tx_pulse(3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL abort_arqn got=%b exp=%b", obs5, exp5); end
    endtask

    task automatic test_flush_collision();
        logic [4:0] fl_exp [3] = '{5'b10111, 5'b10100, 5'b00111};
        logic       fl_on  [3] = '{1'b0, 1'b1, 1'b0};
        logic       fl_arq [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(fl_exp[i]);
            tx_pulse(3'd5, 1'b1, 1'b1, 1'b1, fl_on[i]);
            exp5 = tx_q.pop_front();
            obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
            n_vec++;
            if (obs5 !== exp5) begin n_err++; $display("FAIL flush_tx%0d got=%b exp=%b", i, obs5, exp5); end
            n_vec++;
            if (bus.dec_arqn[5] !== fl_arq[i]) begin
                n_err++; $display("FAIL flush_arqn%0d got=%b exp=%b", i, bus.dec_arqn[5], fl_arq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] bb_exp [3] = '{5'b00111, 5'b10111, 5'b10100};
        @(negedge clk_6M);
        bus.pk_encode = 1'b1; bus.ms_lt_addr = 3'd0; bus.tx_packet_st_p = 1'b1;
        bus.txpktype_data = 1'b1; bus.regi_aclrxbufempty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.regi_txdatready = (i < 2) ? 1'b1 : 1'b0;
            tx_q.push_back(bb_exp[i]);
            @(negedge clk_6M);
            exp5 = tx_q.pop_front();
            obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
            n_vec++;
            if (obs5 !== exp5) begin n_err++; $display("FAIL b2b_bcast%0d got=%b exp=%b", i, obs5, exp5); end
        end
        bus.tx_packet_st_p = 1'b0; bus.pk_encode = 1'b0; bus.regi_txdatready = 1'b0;
    endtask

    task automatic test_reset_midway();
        tx_q.push_back(5'b00100);
        tx_pulse(3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        exp5 = tx_q.pop_front();
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== exp5) begin n_err++; $display("FAIL pre_reset_tx got=%b exp=%b", obs5, exp5); end
        rx_hdr(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #20;
        rstz = 1'b0;
        #1;
        obs5 = {bus.txpk_seqn, bus.txpk_arqn, bus.txpk_flow, bus.sendnewpy, bus.newpy_int_p};
        n_vec++;
        if (obs5 !== 5'b10100) begin n_err++; $display("FAIL midreset_tx got=%b exp=10100", obs5); end
        n_vec++;
        if ({bus.arq_state, bus.dec_arqn, bus.dec_flow} !== 18'h000FF) begin
            n_err++; $display("FAIL midreset_state got=%h exp=000ff", {bus.arq_state, bus.dec_arqn, bus.dec_flow});
        end
        @(negedge clk_6M);
        rstz = 1'b1;
        rx_q.push_back(2'b00);
        rx_py(1'b1);
        exp2 = rx_q.pop_front();
        obs2 = {bus.rx_newpy_p, bus.rx_dup_p};
        n_vec++;
        if (obs2 !== exp2) begin n_err++; $display("FAIL wait_abandoned got=%b exp=%b", obs2, exp2); end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pk_encode = 1'b0; bus.ms_lt_addr = 3'd0; bus.hec_endp = 1'b0;
        bus.dec_hecgood = 1'b0; bus.lt_addressed = 1'b0; bus.rx_arqn = 1'b0;
        bus.rx_flow = 1'b0; bus.rx_seqn = 1'b0; bus.pktype_data = 1'b0;
        bus.py_endp = 1'b0; bus.dec_crcgood = 1'b0; bus.tx_packet_st_p = 1'b0;
        bus.txpktype_data = 1'b0; bus.regi_txdatready = 1'b0;
        bus.regi_aclrxbufempty = 1'b0; bus.regi_flush_p = 1'b0; bus.regi_flush_lt = 3'd0;
        repeat (3) @(negedge clk_6M);
        rstz = 1'b1;
        @(negedge clk_6M);
        test_reset();
        test_first_tx();
        test_ack_advance();
        test_nak_retx();
        test_rx_data();
        test_hec_fail();
        test_abort();
        test_flush_collision();
        test_back_to_back();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
